// File: rtl/clock_counter_12h_pkg.sv
// Shared field limits, widths and wrap helpers for the 12-hour clock core.
// Every helper is total: an out-of-range input still yields a legal next value.
package clock_counter_12h_pkg;

    localparam int HR_W  = 4;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MIN  = 4'd1;
    localparam logic [HR_W-1:0]  HR_MAX  = 4'd12;

    // Wrap at or above the limit so a corrupted field recovers to 0.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic hour_valid(input logic [HR_W-1:0] h);
        return (h >= HR_MIN) && (h <= HR_MAX);
    endfunction

    function automatic logic [HR_W-1:0] hour_inc(input logic [HR_W-1:0] h);
        if (!hour_valid(h)) begin
            return HR_MAX;
        end
        return (h == HR_MAX) ? HR_MIN : h + 4'd1;
    endfunction

    // The AM/PM flag flips when the hour advances from 11 to 12.
    function automatic logic hour_flips_pm(input logic [HR_W-1:0] h);
        return h == (HR_MAX - 4'd1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running CLK_HZ divider producing a registered one-cycle tick.
// The count holds whenever run is low, stretching the period by the held cycles.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered off the terminal count, so it is high in the cycle
    // after the divider wraps, exactly CLK_HZ running cycles apart.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (run) begin
            if (cnt_q == TERM) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/clock_counter_12h.sv
// 12-hour timekeeping core: seconds/minutes/hours cascade on the 1 Hz tick,
// with manual minute/hour set pulses that take priority over the tick.
module clock_counter_12h
    import clock_counter_12h_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             run,
    input  logic             inc_min,
    input  logic             inc_hr,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             pm,
    output logic             tick_1hz
);

    logic             tick_w;
    logic [HR_W-1:0]  hours_q,   hours_d;
    logic [MIN_W-1:0] minutes_q, minutes_d;
    logic [SEC_W-1:0] seconds_q, seconds_d;
    logic             pm_q,      pm_d;
    logic             sec_wrap,  min_wrap;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .run        (run),
        .tick       (tick_w)
    );

    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        pm_d      = pm_q;
        sec_wrap  = seconds_q >= SEC_MAX;
        min_wrap  = minutes_q >= MIN_MAX;

        // Any set pulse swallows a coincident tick's field advance.
        if (inc_min || inc_hr) begin
            if (inc_min) begin
                minutes_d = wrap_inc(minutes_q, MIN_MAX);
                seconds_d = '0;
            end
            if (inc_hr) begin
                hours_d = hour_inc(hours_q);
                pm_d    = pm_q ^ hour_flips_pm(hours_q);
            end
        end else if (tick_w) begin
            seconds_d = wrap_inc(seconds_q, SEC_MAX);
            if (sec_wrap) begin
                minutes_d = wrap_inc(minutes_q, MIN_MAX);
                if (min_wrap) begin
                    hours_d = hour_inc(hours_q);
                    pm_d    = pm_q ^ hour_flips_pm(hours_q);
                end
            end
        end

        // Downstream digit split relies on hours staying within 1..12.
        if (!hour_valid(hours_d)) begin
            hours_d = HR_MAX;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            hours_q   <= HR_MAX;
            minutes_q <= '0;
            seconds_q <= '0;
            pm_q      <= 1'b0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            pm_q      <= pm_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign pm       = pm_q;
    assign tick_1hz = tick_w;

endmodule

// File: tb/tb_clock_counter_12h.sv
// Directed bench for clock_counter_12h: CLK_HZ=10 instance for the functional
// cases and a CLK_HZ=1 instance for a twelve-hour soak.
module tb_clock_counter_12h;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, inc_min, inc_hr;
    logic [3:0] hours;
    logic [5:0] minutes, seconds;
    logic       pm, tick_1hz;

    logic       run2;
    logic       inc_min2 = 1'b0;
    logic       inc_hr2  = 1'b0;
    logic [3:0] hours2;
    logic [5:0] minutes2, seconds2;
    logic       pm2, tick2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_counter_12h #(.CLK_HZ(10)) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .run        (run),
        .inc_min    (inc_min),
        .inc_hr     (inc_hr),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .pm         (pm),
        .tick_1hz   (tick_1hz)
    );

    clock_counter_12h #(.CLK_HZ(1)) dut_fast (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .run        (run2),
        .inc_min    (inc_min2),
        .inc_hr     (inc_hr2),
        .hours      (hours2),
        .minutes    (minutes2),
        .seconds    (seconds2),
        .pm         (pm2),
        .tick_1hz   (tick2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int p);
        check_eq({tag, ".hr"},  32'(hours),   32'(h));
        check_eq({tag, ".min"}, 32'(minutes), 32'(m));
        check_eq({tag, ".sec"}, 32'(seconds), 32'(s));
        check_eq({tag, ".pm"},  32'(pm),      32'(p));
        $display("%s: %0d:%02d:%02d %s", tag, hours, minutes, seconds, pm ? "PM" : "AM");
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ends on the negedge where tick_1hz is visible; n = negedges waited.
    task automatic seek_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_1hz && n < 40);
        check_eq("tick_seen", 32'(tick_1hz), 32'd1);
    endtask

    task automatic wait_ticks(input int k);
        int n;
        repeat (k) begin
            seek_tick(n);
            step(1);
        end
    endtask

    task automatic pulse_min(input int k);
        repeat (k) begin
            inc_min = 1'b1;
            step(1);
            inc_min = 1'b0;
        end
    endtask

    task automatic pulse_hr(input int k);
        repeat (k) begin
            inc_hr = 1'b1;
            step(1);
            inc_hr = 1'b0;
        end
    endtask

    initial begin
        int n;
        int pm_flips;
        int bad_hr;
        int ticks_seen;
        logic pm_prev;

        reset_n = 1'b0;
        run     = 1'b1;
        run2    = 1'b0;
        inc_min = 1'b0;
        inc_hr  = 1'b0;

        step(2);
        check_time("reset", 12, 0, 0, 0);
        check_eq("reset.tick", 32'(tick_1hz), 32'd0);

        // Let two ticks land, then drop reset between edges.
        reset_n = 1'b1;
        step(25);
        check_time("pre_reset", 12, 0, 2, 0);
        #2 reset_n = 1'b0;
        #1;
        check_time("async_reset", 12, 0, 0, 0);
        check_eq("async_reset.tick", 32'(tick_1hz), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seek_tick(n);
        check_eq("first_tick_latency", 32'(n), 32'd10);
        step(1);
        check_eq("tick_pulse_width", 32'(tick_1hz), 32'd0);
        check_time("first_tick", 12, 0, 1, 0);

        // 12:59:59 AM -> 1:00:00 AM, pm unchanged.
        run = 1'b0;
        pulse_min(59);
        check_time("set_1259", 12, 59, 0, 0);
        run = 1'b1;
        wait_ticks(59);
        check_time("at_125959", 12, 59, 59, 0);
        wait_ticks(1);
        check_time("roll_12_to_1", 1, 0, 0, 0);

        // 11:59:59 AM -> 12:00:00 PM.
        run = 1'b0;
        pulse_hr(10);
        pulse_min(59);
        run = 1'b1;
        wait_ticks(59);
        check_time("at_115959_am", 11, 59, 59, 0);
        wait_ticks(1);
        check_time("roll_to_noon", 12, 0, 0, 1);

        // 11:59:59 PM -> 12:00:00 AM, all fields on one edge.
        run = 1'b0;
        pulse_hr(11);
        pulse_min(59);
        run = 1'b1;
        wait_ticks(59);
        seek_tick(n);
        check_time("tick_cycle_11pm", 11, 59, 59, 1);
        step(1);
        check_time("roll_to_midnight", 12, 0, 0, 0);

        // inc_min at 59 wraps without carry and clears seconds.
        run = 1'b0;
        pulse_min(59);
        run = 1'b1;
        wait_ticks(5);
        run = 1'b0;
        check_time("before_min_wrap", 12, 59, 5, 0);
        pulse_min(1);
        check_time("inc_min_wrap", 12, 0, 0, 0);

        // inc_hr x12 from 12 AM visits 1..11 then 12 PM.
        for (int k = 1; k <= 12; k++) begin
            pulse_hr(1);
            check_eq($sformatf("inc_hr_step%0d.hr", k), 32'(hours), 32'(k));
            check_eq($sformatf("inc_hr_step%0d.pm", k), 32'(pm), (k == 12) ? 32'd1 : 32'd0);
        end

        // inc_min colliding with a tick at 3:10:30 PM.
        pulse_hr(3);
        pulse_min(10);
        run = 1'b1;
        wait_ticks(30);
        check_time("at_031030", 3, 10, 30, 1);
        seek_tick(n);
        inc_min = 1'b1;
        step(1);
        inc_min = 1'b0;
        check_time("collision", 3, 11, 0, 1);

        // Hold run low 7 cycles mid-count with an inc_hr during the hold.
        seek_tick(n);
        step(3);
        run = 1'b0;
        step(2);
        inc_hr = 1'b1;
        step(1);
        inc_hr = 1'b0;
        step(4);
        run = 1'b1;
        seek_tick(n);
        check_eq("run_gate_period", 32'(3 + 7 + n), 32'd17);
        check_eq("run_gate_inc_hr", 32'(hours), 32'd4);
        check_eq("run_gate_pm", 32'(pm), 32'd1);

        // Twelve hours on the CLK_HZ=1 instance: one tick per cycle.
        pm_flips   = 0;
        bad_hr     = 0;
        ticks_seen = 0;
        pm_prev    = pm2;
        run2       = 1'b1;
        for (int c = 0; c < 43300 && ticks_seen < 43200; c++) begin
            @(negedge clk);
            if (tick2) ticks_seen++;
            if (pm2 !== pm_prev) pm_flips++;
            pm_prev = pm2;
            if (hours2 < 4'd1 || hours2 > 4'd12) bad_hr++;
        end
        run2 = 1'b0;
        step(2);
        if (pm2 !== pm_prev) pm_flips++;
        check_eq("soak.ticks", 32'(ticks_seen), 32'd43200);
        check_eq("soak.hr", 32'(hours2), 32'd12);
        check_eq("soak.min", 32'(minutes2), 32'd0);
        check_eq("soak.sec", 32'(seconds2), 32'd0);
        check_eq("soak.pm", 32'(pm2), 32'd1);
        check_eq("soak.pm_flips", 32'(pm_flips), 32'd1);
        check_eq("soak.hr_range", 32'(bad_hr), 32'd0);
        $display("soak: %0d ticks -> %0d:%02d:%02d pm=%0d flips=%0d",
                 ticks_seen, hours2, minutes2, seconds2, pm2, pm_flips);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
